// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//   Accepts an M-extension op from the ID/EX register. It computes the result
//   over XLEN cycles and holds stall_req while it does so. It then presents
//   the result with a one-cycle result_valid pulse.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             valid M-ext op present in EX (sampled only when idle)
//   funct3            000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                     100 DIV,101 DIVU,110 REM,111 REMU
//   op_a, op_b        rs1 / rs2 values after forwarding
//   rd_addr           destination register of the op
//   flush             pipeline flush, aborts any op in flight
//   busy              unit is not idle
//   stall_req         freeze request to the hazard unit
//   result            final result, meaningful only with result_valid
//   result_valid      one-cycle write-back pulse
//   rd_addr_o         rd captured at start
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   ma_q, ma_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for the op presented in IDLE
  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_result;

  // One iteration step, shared datapath register work_q:
  //   multiply: {partial high word, remaining multiplier bits}
  //   divide:   {partial remainder, remaining dividend / quotient bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fin_result;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    mag_a    = sa ? -op_a : op_a;
    mag_b    = sb ? -op_b : op_b;

    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (op_a == MIN_NEG) && (op_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) begin
      fast_result = funct3[1] ? op_a : '1;
    end else begin
      fast_result = funct3[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, ma_q} : '0);
    mul_next  = {mul_sum, work_q[XLEN-1:1]};

    // Guard bit: div_diff[XLEN] set means the trial subtraction went negative
    div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, ma_q};
    if (div_diff[XLEN]) begin
      div_next = {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
    end
    step_next = f3_q[2] ? div_next : mul_next;

    // Result is formed from the final step so it is registered on entry to DONE
    prod_s = neg_q ? -step_next : step_next;
    quo    = step_next[XLEN-1:0];
    rem    = step_next[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:          fin_result = prod_s[XLEN-1:0];
      3'b100, 3'b101:  fin_result = neg_q ? -quo : quo;
      3'b110, 3'b111:  fin_result = neg_q ? -rem : rem;
      default:         fin_result = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    ma_d     = ma_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d   = funct3;
          rd_d   = rd_addr;
          cnt_d  = '0;
          // Remainder takes the dividend's sign, everything else the product of signs
          neg_d  = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
          ma_d   = funct3[2] ? mag_b : mag_a;
          work_d = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
          if (fast) begin
            result_d = fast_result;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          work_d = step_next;
          cnt_d  = cnt_q + CNTW'(1);
          if (cnt_q == LAST_CNT) begin
            result_d = fin_result;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      ma_q     <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      ma_q     <= ma_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign stall_req    = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
  assign result_valid = (state_q == S_DONE) && !flush;
  assign result       = result_q;
  assign rd_addr_o    = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv. The stimulus pushes the
// expected result and rd for each op. A negedge monitor pops and compares
// them whenever result_valid is seen.
module tb_ex_muldiv;

  localparam int FAST = 1;
  localparam int SLOW = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, stall_req, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_addr_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  ex_muldiv #(.XLEN(32), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .stall_req(stall_req), .result(result),
    .result_valid(result_valid), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && result_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h rd %0d expected no pulse", result, rd_addr_o);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_rd"}, 32'(rd_addr_o), 32'(e.rd));
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int stalls;
    bit seen;
    sb_q.push_back('{res: exp, rd: rd, name: name});
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_addr = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; stalls = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (result_valid) begin
        seen = 1'b1;
        check({name, "_stall_in_done"}, 32'(stall_req), 32'd0);
      end else if (stall_req) begin
        stalls++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result_valid in 100 cycles expected one after %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Multiply
    run_op("mul_7_m3",       3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, SLOW);
    run_op("mulhu_m1_m1",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, SLOW);
    run_op("mulh_m1_m1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, SLOW);
    run_op("mulhsu_m1_2",    3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, SLOW);
    run_op("mulh_min_min",   3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, SLOW);
    run_op("mulhsu_min_max", 3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, SLOW);

    // Divide / remainder
    run_op("div_m7_2",       3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, SLOW);
    run_op("rem_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, SLOW);
    run_op("remu_100_7",     3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        SLOW);
    run_op("divu_100_7",     3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       SLOW);
    run_op("div_7_m2",       3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, SLOW);
    run_op("rem_7_m2",       3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        SLOW);
    run_op("divu_max_1",     3'b101, 32'hFFFFFFFF, 32'd1,        5'd13, 32'hFFFFFFFF, SLOW);
    run_op("div_min_1",      3'b100, 32'h80000000, 32'd1,        5'd14, 32'h80000000, SLOW);

    // Fast paths
    run_op("div_by_zero",    3'b100, 32'd1234,     32'd0,        5'd15, 32'hFFFFFFFF, FAST);
    run_op("divu_by_zero",   3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, FAST);
    run_op("remu_by_zero",   3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        FAST);
    run_op("rem_by_zero",    3'b110, 32'hFFFFFFF0, 32'd0,        5'd18, 32'hFFFFFFF0, FAST);
    run_op("div_overflow",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, FAST);
    run_op("rem_overflow",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        FAST);

    // Flush 10 cycles into CALC: op dropped, no pulse
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_addr = 5'd21; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    check("flush_calc_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_calc_busy", 32'(busy), 32'd0);
    check("flush_calc_valid", 32'(result_valid), 32'd0);
    repeat (40) @(negedge clk);
    run_op("after_flush_mul", 3'b000, 32'd3, 32'd5, 5'd22, 32'd15, SLOW);

    // Flush together with start in IDLE: op not accepted
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1; op_b = 32'd0; rd_addr = 5'd23;
    start = 1'b1; flush = 1'b1;
    #1 check("flush_idle_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(busy), 32'd0);

    // Flush in DONE: pulse suppressed
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; rd_addr = 5'd24; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b1;
    check("flush_done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("flush_done_valid", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_addr = 5'd25; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_still_idle", 32'(busy), 32'd0);

    // Back-to-back ops
    run_op("b2b_divu", 3'b101, 32'd1000, 32'd10, 5'd26, 32'd100, SLOW);
    run_op("b2b_mul",  3'b000, 32'd1000, 32'd10, 5'd27, 32'd10000, SLOW);
    run_op("b2b_rem",  3'b110, 32'd1,    32'd0,  5'd28, 32'd1, FAST);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
